// File: rtl/fc_relu_serializer.sv
// Frame unpacker: collects BEATS wide beats of LANES words and streams them out one word per
// transfer in natural index order n = BEATS*lane + beat.
module fc_relu_serializer #(
  parameter int unsigned DW    = 32,
  parameter int unsigned LANES = 128,
  parameter int unsigned BEATS = 4,
  localparam int unsigned IW   = $clog2(LANES * BEATS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic [IW-1:0]       out_idx,
  output logic                out_last
);

  // LANES and BEATS are both powers of two, so n splits into {lane, beat} bit fields.
  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LW = IW - BW;

  localparam logic [IW-1:0] LastIdx  = IW'(LANES * BEATS - 1);
  localparam logic [BW-1:0] LastBeat = BW'(BEATS - 1);

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]          state;
  logic [BW-1:0]       beat_cnt;
  logic [IW-1:0]       rd_cnt;
  logic                accept;
  logic                xfer;
  logic [BW-1:0]       rd_beat;
  logic [LW-1:0]       rd_lane;
  logic [LANES*DW-1:0] lane_words;
  logic [DW-1:0]       rd_word;

  // Reset dominates: no beat is written into storage while rst_n is low.
  assign accept  = rst_n && in_valid && in_ready;
  assign xfer    = out_valid && out_ready;
  assign rd_beat = rd_cnt[BW-1:0];
  assign rd_lane = rd_cnt[IW-1:BW];

  // Per-lane storage; each lane holds one word per beat and selects the beat being read.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DW-1:0] lane_mem [BEATS];

    always_ff @(posedge clk) begin
      if (accept) begin
        lane_mem[beat_cnt] <= in_data[k*DW +: DW];
      end
    end

    assign lane_words[k*DW +: DW] = lane_mem[rd_beat];
  end

  assign rd_word = lane_words[rd_lane*DW +: DW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      beat_cnt  <= '0;
      rd_cnt    <= '0;
    end else begin
      unique case (state)
        ST_FILL: begin
          if (accept) begin
            if (beat_cnt == LastBeat) begin
              // rd_cnt is 0 throughout FILL, so rd_word already addresses word 0.
              state     <= ST_DRAIN;
              in_ready  <= 1'b0;
              beat_cnt  <= '0;
              out_valid <= 1'b1;
              out_data  <= rd_word;
              out_idx   <= '0;
              out_last  <= 1'b0;
              rd_cnt    <= IW'(1);
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (xfer) begin
            if (out_idx != LastIdx) begin
              out_data <= rd_word;
              out_idx  <= rd_cnt;
              out_last <= (rd_cnt == LastIdx);
              rd_cnt   <= rd_cnt + IW'(1);
            end else begin
              state     <= ST_FILL;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              rd_cnt    <= '0;
            end
          end
        end
        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_relu_serializer.sv
// Scoreboard bench for fc_relu_serializer: frame order, backpressure, input gaps, resets.
module tb_fc_relu_serializer;

  localparam int DW    = 32;
  localparam int LANES = 128;
  localparam int BEATS = 4;
  localparam int NW    = LANES * BEATS;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [8:0]    idx;
    logic          last;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [LANES*DW-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_data;
  logic [8:0]          out_idx;
  logic                out_last;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_xfer_cyc = 0;

  fc_relu_serializer #(
    .DW   (DW),
    .LANES(LANES),
    .BEATS(BEATS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Every valid word is compared to the scoreboard head; it is popped only when transferred,
  // so a stalled word must stay equal to the same expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("in_ready_in_drain", {63'd0, in_ready}, 64'd0);
      if (q.size() == 0) begin
        check("spurious_word", {63'd0, out_valid}, 64'd0);
      end else begin
        check("out_data", {32'd0, out_data}, {32'd0, q[0].data});
        check("out_idx", {55'd0, out_idx}, {55'd0, q[0].idx});
        check("out_last", {63'd0, out_last}, {63'd0, q[0].last});
        if (out_ready) begin
          if (q[0].last) last_xfer_cyc = cyc + 1;
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic send_beats(input int base, input int nbeats, input int gap, input bit keep,
                            output int acc0);
    acc0 = -1;
    for (int b = 0; b < nbeats; b++) begin
      int t = 0;
      in_valid = 1'b1;
      for (int k = 0; k < LANES; k++) in_data[k*DW +: DW] = DW'(base + BEATS * k + b);
      while (1) begin
        @(negedge clk);
        if (in_ready) break;
        t++;
        if (t > 4000) begin
          check("in_ready_timeout", 64'(t), 64'd0);
          break;
        end
      end
      @(posedge clk);
      #1;
      if (b == 0) acc0 = cyc;
      if (gap > 0 && b != nbeats - 1) begin
        in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input int gap, input bit keep, output int acc0);
    for (int n = 0; n < NW; n++) begin
      exp_t e;
      e.data = DW'(base + n);
      e.idx  = 9'(n);
      e.last = (n == NW - 1);
      q.push_back(e);
    end
    send_beats(base, BEATS, gap, keep, acc0);
  endtask

  task automatic wait_drain(output int cnt);
    cnt = 0;
    while (1) begin
      @(negedge clk);
      if (!out_valid) break;
      cnt++;
      if (cnt > 4000) begin
        check("drain_timeout", 64'(cnt), 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idx(input int n);
    int t = 0;
    while (1) begin
      @(posedge clk);
      #1;
      if (out_valid && out_idx == 9'(n)) break;
      t++;
      if (t > 4000) begin
        check("wait_idx_timeout", 64'(t), 64'd0);
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int acc0;
    int acc1;
    int cnt;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_last", {63'd0, out_last}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_out_idx", {55'd0, out_idx}, 64'd0);

    // T1: plain frame, out_valid right after the last beat edge, 512 back-to-back words
    send_frame(0, 0, 1'b0, acc0);
    check("t1_latency_valid", {63'd0, out_valid}, 64'd1);
    check("t1_in_ready_low", {63'd0, in_ready}, 64'd0);
    wait_drain(cnt);
    check("t1_cycles", 64'(cnt), 64'(NW));
    check("t1_in_ready_back", {63'd0, in_ready}, 64'd1);
    check("t1_sb_empty", 64'(q.size()), 64'd0);

    // T2: stall 5 cycles at word 100, then toggle out_ready
    send_frame(0, 0, 1'b0, acc0);
    wait_idx(100);
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t2_held_idx", {55'd0, out_idx}, 64'd100);
    check("t2_held_data", {32'd0, out_data}, 64'd100);
    cnt = 0;
    while (out_valid && cnt < 4000) begin
      out_ready = ~out_ready;
      @(posedge clk);
      #1;
      cnt++;
    end
    out_ready = 1'b1;
    check("t2_drained", {63'd0, out_valid}, 64'd0);
    check("t2_sb_empty", 64'(q.size()), 64'd0);

    // T3: idle gaps between beats, junk offered during drain must be ignored
    send_frame(0, 3, 1'b0, acc0);
    in_valid = 1'b1;
    for (int k = 0; k < LANES; k++) in_data[k*DW +: DW] = $urandom;
    repeat (100) @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain(cnt);
    check("t3_sb_empty", 64'(q.size()), 64'd0);

    // T4: reset at word 200, then a fresh frame of values 1000..1511
    send_frame(0, 0, 1'b0, acc0);
    wait_idx(200);
    pulse_reset();
    check("t4_out_valid", {63'd0, out_valid}, 64'd0);
    check("t4_in_ready", {63'd0, in_ready}, 64'd1);
    send_frame(1000, 0, 1'b0, acc0);
    wait_drain(cnt);
    check("t4_sb_empty", 64'(q.size()), 64'd0);

    // T5: back-to-back frames with in_valid held high
    send_frame(2000, 0, 1'b1, acc0);
    send_frame(3000, 0, 1'b0, acc1);
    check("t5_first_beat_edge", 64'(acc1 - last_xfer_cyc), 64'd1);
    wait_drain(cnt);
    check("t5_sb_empty", 64'(q.size()), 64'd0);

    // Reset after two beats: the next frame must start again at beat 0
    send_beats(5000, 2, 0, 1'b0, acc0);
    pulse_reset();
    send_frame(6000, 0, 1'b0, acc0);
    wait_drain(cnt);
    check("t5_restart_cycles", 64'(cnt), 64'(NW));
    check("t5_restart_sb_empty", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
